// File: rtl/lock_attempt_controller_if.sv
// lock_attempt_controller_if
//   Groups the keypad strobe, the lockout timer start/done handshake and the
//   controller status outputs into one bundle.
//   master : the code-entry controller (drives lockout_start and status,
//            receives keys and lock_done)
//   slave  : the environment (keypad + lockout timer + status consumers)
// Signals:
//   key_valid     1  one-cycle strobe per keypress
//   key_code      4  0-9 digit, A clear, B enter, C relock, D-F ignored
//   lock_done     1  level from lockout timer, high when countdown expired
//   lockout_start 1  one-cycle pulse that starts/restarts the lockout timer
//   locked_out    1  high while lockout in progress
//   unlocked      1  high while correct code accepted
//   bad_code      1  one-cycle pulse per failed attempt
//   digit_count   3  digits currently buffered
//   fail_count    3  consecutive failures since last success/lockout
interface lock_attempt_controller_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       lock_done;
    logic       lockout_start;
    logic       locked_out;
    logic       unlocked;
    logic       bad_code;
    logic [2:0] digit_count;
    logic [2:0] fail_count;

    modport master (
        input  key_valid,
        input  key_code,
        input  lock_done,
        output lockout_start,
        output locked_out,
        output unlocked,
        output bad_code,
        output digit_count,
        output fail_count
    );

    modport slave (
        output key_valid,
        output key_code,
        output lock_done,
        input  lockout_start,
        input  locked_out,
        input  unlocked,
        input  bad_code,
        input  digit_count,
        input  fail_count
    );
endinterface

// File: rtl/lock_attempt_controller.sv
// lock_attempt_controller
//   Keypad code-entry controller. Buffers digit keypresses, compares the
//   entry against SECRET on the enter key, drives unlocked, counts
//   consecutive failures and, at MAX_FAILS, starts a lockout on the
//   countdown timer, then ignores all keys until the timer reports done.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    lock_attempt_controller_if.master (keys, lockout handshake, status)
// All outputs are registered: a key accepted at edge N is visible after N.
module lock_attempt_controller #(
    parameter int                      CODE_LEN  = 4,
    parameter logic [4*CODE_LEN-1:0]   SECRET    = 16'h1234,
    parameter int                      MAX_FAILS = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    lock_attempt_controller_if.master     bus
);

    localparam int         BUF_W     = 4 * CODE_LEN;
    localparam logic [2:0] LEN_C     = 3'(CODE_LEN);
    localparam logic [2:0] MAX_C     = 3'(MAX_FAILS);

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [3:0] KEY_RELOCK = 4'hC;

    typedef enum logic [2:0] {
        ENTRY,
        UNLOCKED,
        LOCK_START,
        LOCK_ARM,
        LOCK_WAIT
    } state_t;

    state_t             state_reg, state_next;
    logic [BUF_W-1:0]   buffer_reg, buffer_next;
    logic [2:0]         digit_count_reg, digit_count_next;
    logic [2:0]         fail_count_reg, fail_count_next;
    logic               bad_code_reg, bad_code_next;
    logic               lockout_start_reg, lockout_start_next;
    logic               locked_out_reg, locked_out_next;
    logic               unlocked_reg, unlocked_next;

    logic [BUF_W-1:0]   buffer_shifted;
    logic [2:0]         fail_inc;
    logic               is_digit;

    // Buffer with the new digit shifted in at the least significant nibble.
    // Built per nibble so CODE_LEN=1 needs no degenerate slice.
    for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_shift
        if (gi == 0) begin : g_low
            assign buffer_shifted[3:0] = bus.key_code;
        end else begin : g_up
            assign buffer_shifted[4*gi +: 4] = buffer_reg[4*(gi-1) +: 4];
        end
    end

    assign is_digit = (bus.key_code <= 4'd9);
    assign fail_inc = fail_count_reg + 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ENTRY;
            buffer_reg        <= '0;
            digit_count_reg   <= '0;
            fail_count_reg    <= '0;
            bad_code_reg      <= 1'b0;
            lockout_start_reg <= 1'b0;
            locked_out_reg    <= 1'b0;
            unlocked_reg      <= 1'b0;
        end else begin
            state_reg         <= state_next;
            buffer_reg        <= buffer_next;
            digit_count_reg   <= digit_count_next;
            fail_count_reg    <= fail_count_next;
            bad_code_reg      <= bad_code_next;
            lockout_start_reg <= lockout_start_next;
            locked_out_reg    <= locked_out_next;
            unlocked_reg      <= unlocked_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        buffer_next      = buffer_reg;
        digit_count_next = digit_count_reg;
        fail_count_next  = fail_count_reg;
        bad_code_next    = 1'b0;

        unique case (state_reg)
            ENTRY: begin
                if (bus.key_valid) begin
                    if (is_digit) begin
                        // A full buffer ignores further digits (no wrap).
                        if (digit_count_reg < LEN_C) begin
                            buffer_next      = buffer_shifted;
                            digit_count_next = digit_count_reg + 3'd1;
                        end
                    end else if (bus.key_code == KEY_CLEAR) begin
                        buffer_next      = '0;
                        digit_count_next = '0;
                    end else if (bus.key_code == KEY_ENTER) begin
                        buffer_next      = '0;
                        digit_count_next = '0;
                        if (digit_count_reg == LEN_C && buffer_reg == SECRET) begin
                            state_next      = UNLOCKED;
                            fail_count_next = '0;
                        end else begin
                            bad_code_next   = 1'b1;
                            fail_count_next = fail_inc;
                            if (fail_inc == MAX_C) begin
                                state_next = LOCK_START;
                            end
                        end
                    end
                end
            end
            UNLOCKED: begin
                if (bus.key_valid && bus.key_code == KEY_RELOCK) begin
                    state_next = ENTRY;
                end
            end
            LOCK_START: begin
                state_next = LOCK_ARM;
            end
            LOCK_ARM: begin
                // A done level left high by an earlier lockout must drop
                // before the new countdown's done can be trusted.
                if (!bus.lock_done) begin
                    state_next = LOCK_WAIT;
                end
            end
            LOCK_WAIT: begin
                if (bus.lock_done) begin
                    state_next      = ENTRY;
                    fail_count_next = '0;
                end
            end
            default: begin
                state_next = ENTRY;
            end
        endcase

        // Status outputs follow the state being entered so they register
        // in the same edge as the state change.
        unlocked_next      = (state_next == UNLOCKED);
        lockout_start_next = (state_next == LOCK_START);
        locked_out_next    = (state_next == LOCK_START) ||
                             (state_next == LOCK_ARM)   ||
                             (state_next == LOCK_WAIT);
    end

    assign bus.lockout_start = lockout_start_reg;
    assign bus.locked_out    = locked_out_reg;
    assign bus.unlocked      = unlocked_reg;
    assign bus.bad_code      = bad_code_reg;
    assign bus.digit_count   = digit_count_reg;
    assign bus.fail_count    = fail_count_reg;

endmodule
